alu_accum_core: RTL and testbench
=================================

# alu_accum_core

Parametrised, sequential successor to the 4-bit combinational ALU. It holds an internal accumulator and accepts one operation at a time over a valid/ready handshake. Single-cycle ops return a registered result with flags after one cycle; multiply is a multi-cycle shift-add that blocks new input while it runs. It sits between the switch/bidirectional-pin input capture and the result display path of the chip top.

## Interface
- `WIDTH`, default 8: operand, accumulator and result width; legal range is 4 to 32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous reset, active low.
- `in_valid` input 1: an operation is presented this cycle.
- `in_ready` output 1: the block can accept an operation this cycle.
- `op` input 4: operation code (see Operation).
- `use_acc` input 1: 1 selects the accumulator as operand A; 0 selects `operand_a`.
- `operand_a` input WIDTH: external A operand.
- `operand_b` input WIDTH: B operand.
- `out_valid` output 1: one-cycle pulse; `result` and `flags` are new.
- `result` output WIDTH: registered result; holds until the next completion.
- `flags` output 4: {Z, N, C, V}; registered alongside `result`.
- `busy` output 1: a multiply is in progress.

## Operation
- **Handshake:** an op is accepted on a rising edge where `in_valid` and `in_ready` are both 1. Operands are captured at that edge. `in_ready` = (state == IDLE).
- **States:**
  - IDLE: accept op.
  - Single-cycle op: compute, register, stay in IDLE.
  - MUL: enter MUL with a counter set to WIDTH.
  - MUL exit: on the edge the counter reaches 0, register the result and return to IDLE.
- **Op codes** (A = acc or `operand_a`, B = `operand_b`, all unsigned unless stated):
  - 0 ADD: A+B. C = carry out; V = signed overflow.
  - 1 SUB: A−B. C = borrow (A<B); V = signed overflow.
  - 2 AND, 3 OR, 8 XOR: bitwise.
  - 4 EQ, 6 GT, 7 LT: result is all ones if true, else 0.
  - 5 NOT: ~A.
  - 9 SHL: A<<1. C = A[WIDTH-1].
  - 10 SHR: A>>1 (logical). C = A[0].
  - 11 MUL: low WIDTH bits of A*B. C = 1 if the upper WIDTH bits are nonzero.
  - 12 CLR: result 0.
  - 13 LOAD: result B.
  - 14, 15: result 0.
- **Flags:**
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - C and V are 0 for every op except where listed above.
- **Accumulator:** loaded with `result` on every completion, including CLR/LOAD and unused codes.
- **No output back-pressure:** `out_valid` is a pulse, and the consumer must capture it.

## Timing
- **Reset** (asynchronous, immediate): accumulator = 0, `result` = 0, `flags` = 0, `out_valid` = 0, `busy` = 0, state = IDLE.
  - `in_ready` = 1 once `rst_n` is released.
  - Reset during MUL aborts it. No `out_valid` is produced, and the partial product is discarded.
- **Single-cycle op** accepted at edge k: `result`/`flags` update and `out_valid` = 1 during the cycle following edge k. `in_ready` stays 1, so back-to-back accepts run one op per cycle.
- **MUL** accepted at edge k:
  - `in_ready` = 0 and `busy` = 1 from edge k to edge k+WIDTH.
  - Result registers at edge k+WIDTH; `out_valid` = 1 in the following cycle, with `in_ready` = 1 again in that same cycle.
  - Latency is WIDTH cycles.
  - `in_valid` while `in_ready` = 0 is ignored, not queued.
- **Operand sampling for MUL:** operands are sampled only at accept. Input changes during MUL have no effect.
- **`use_acc` = 1:** reads the accumulator value as of the accept edge. An op accepted in the same cycle that `out_valid` reports a prior result therefore sees that prior result.

## Test plan
- ADD, WIDTH=8, `use_acc`=0, A=200, B=100 → `result`=0x2C, flags Z0 N0 C1 V0, `out_valid` exactly 1 cycle after accept.
- SUB, A=5, B=7 → `result`=0xFE, flags Z0 N1 C1 V0. Then SUB A=0x80, B=1 → 0x7F, V=1, C=0.
- MUL, A=13, B=11 → 0x8F, C=0, `out_valid` 8 cycles after accept. MUL A=20, B=20 → 0x90, C=1. During the busy window, `in_valid` is held high with op ADD; no extra `out_valid` is produced and `in_ready` stays 0 until the result.
- Back-to-back chain with `in_valid` held high: LOAD B=3, then ADD (`use_acc`=1, B=4), then SHL (`use_acc`=1) → results 3, 7, 14 on consecutive cycles, accumulator = 14.
- Reset asserted on the 4th cycle of MUL A=255, B=255 → all outputs 0 immediately, no `out_valid`. After release, `in_ready`=1, and ADD (`use_acc`=1, B=0) → 0 with Z=1.
- EQ A=B=0x5A → 0xFF, N=1. GT A=3, B=9 → 0, Z=1. Op 15 → 0, Z=1, accumulator = 0.

Source files
------------

// File: rtl/alu_accum_core.sv
// Accumulator ALU: single-cycle ops complete in one cycle, MUL is a WIDTH-cycle shift-add.
// Results and flags are registered; the accumulator follows every completed result.
module alu_accum_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_EQ   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_GT   = 4'd6;
  localparam logic [3:0] OP_LT   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_LOAD = 4'd13;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         flags_q, flags_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   op_a;
  logic [WIDTH:0]     add_w, sub_w;
  logic [2*WIDTH-1:0] prod_next;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic               fin;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_c, fin_v;

  assign op_a      = use_acc ? acc_q : operand_a;
  assign add_w     = {1'b0, op_a} + {1'b0, operand_b};
  // The extended MSB of the difference is the borrow (A < B).
  assign sub_w     = {1'b0, op_a} - {1'b0, operand_b};
  assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] == operand_b[WIDTH-1]) && (add_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (op_a[WIDTH-1] != operand_b[WIDTH-1]) && (sub_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  alu_res = op_a & operand_b;
      OP_OR:   alu_res = op_a | operand_b;
      OP_XOR:  alu_res = op_a ^ operand_b;
      OP_EQ:   alu_res = {WIDTH{op_a == operand_b}};
      OP_GT:   alu_res = {WIDTH{op_a > operand_b}};
      OP_LT:   alu_res = {WIDTH{op_a < operand_b}};
      OP_NOT:  alu_res = ~op_a;
      OP_SHL: begin
        alu_res = {op_a[WIDTH-2:0], 1'b0};
        alu_c   = op_a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {1'b0, op_a[WIDTH-1:1]};
        alu_c   = op_a[0];
      end
      OP_LOAD: alu_res = operand_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    fin         = 1'b0;
    fin_res     = '0;
    fin_c       = 1'b0;
    fin_v       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = CW'(WIDTH);
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = operand_b;
            prod_d   = '0;
          end else begin
            fin     = 1'b1;
            fin_res = alu_res;
            fin_c   = alu_c;
            fin_v   = alu_v;
          end
        end
      end
      S_MUL: begin
        prod_d   = prod_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last partial product is folded in on the same edge that completes.
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          fin     = 1'b1;
          fin_res = prod_next[WIDTH-1:0];
          fin_c   = |prod_next[2*WIDTH-1:WIDTH];
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      result_d    = fin_res;
      acc_d       = fin_res;
      flags_d     = {(fin_res == '0), fin_res[WIDTH-1], fin_c, fin_v};
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_accum_core.sv
// Scoreboarded bench for alu_accum_core at WIDTH=8; expected results are fixed constants.
module tb_alu_accum_core;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic         use_acc;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         out_valid;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_accum_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_acc(use_acc), .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .result(result), .flags(flags), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every out_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid at cycle %0d result=%h", cyc, result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (result !== e.res) begin
          errors++;
          $display("FAIL result got=%h exp=%h (cycle %0d)", result, e.res, cyc);
        end
        checks++;
        if (flags !== e.flg) begin
          errors++;
          $display("FAIL flags got=%b exp=%b (cycle %0d)", flags, e.flg, cyc);
        end
        checks++;
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL latency out_valid cycle got=%0d exp=%0d", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Presents one op at a negedge; it is accepted at the following posedge.
  task automatic issue(input logic [3:0] o, input logic ua, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef,
                       input bit push);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; op = o; use_acc = ua; operand_a = a; operand_b = b;
    if (push) begin
      e.res = er; e.flg = ef;
      e.cyc = cyc + 1 + ((o == 4'd11) ? W : 0);
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic single(input logic [3:0] o, input logic ua, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic [3:0] ef);
    issue(o, ua, a, b, er, ef, 1'b1);
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; op = '0; use_acc = 1'b0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== '0 || flags !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got res=%h flg=%b ov=%b busy=%b exp all 0",
               result, flags, out_valid, busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_add_sub();
    single(4'd0, 1'b0, 8'd200, 8'd100, 8'h2C, 4'b0010);
    single(4'd1, 1'b0, 8'd5,   8'd7,   8'hFE, 4'b0110);
    single(4'd1, 1'b0, 8'h80,  8'd1,   8'h7F, 4'b0001);
  endtask

  task automatic test_logic();
    single(4'd2,  1'b0, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    single(4'd3,  1'b0, 8'hF0, 8'h0F, 8'hFF, 4'b0100);
    single(4'd8,  1'b0, 8'hAA, 8'hAA, 8'h00, 4'b1000);
    single(4'd5,  1'b0, 8'h0F, 8'h00, 8'hF0, 4'b0100);
    single(4'd10, 1'b0, 8'h81, 8'h00, 8'h40, 4'b0010);
    single(4'd9,  1'b0, 8'h81, 8'h00, 8'h02, 4'b0010);
    single(4'd12, 1'b0, 8'h55, 8'h66, 8'h00, 4'b1000);
  endtask

  task automatic test_compare();
    single(4'd4,  1'b0, 8'h5A, 8'h5A, 8'hFF, 4'b0100);
    single(4'd6,  1'b0, 8'd3,  8'd9,  8'h00, 4'b1000);
    single(4'd7,  1'b0, 8'd3,  8'd9,  8'hFF, 4'b0100);
    single(4'd13, 1'b0, 8'h00, 8'h21, 8'h21, 4'b0000);
    single(4'd15, 1'b0, 8'h12, 8'h34, 8'h00, 4'b1000);
    single(4'd0,  1'b1, 8'hEE, 8'h00, 8'h00, 4'b1000);
  endtask

  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef);
    issue(4'd11, 1'b0, a, b, er, ef, 1'b1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Ignored traffic during the multiply, with changed operands.
        op = 4'd0; operand_a = 8'h01; operand_b = 8'h01; in_valid = 1'b1;
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mul_busy_window step %0d got rdy=%b busy=%b ov=%b exp 0 1 0",
                 i, in_ready, busy, out_valid);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mul_done_ready got rdy=%b busy=%b exp 1 0", in_ready, busy);
    end
  endtask

  task automatic test_mul();
    run_mul(8'd13, 8'd11, 8'h8F, 4'b0100);
    single(4'd0, 1'b1, 8'h00, 8'h00, 8'h8F, 4'b0100);
    run_mul(8'd20, 8'd20, 8'h90, 4'b0110);
  endtask

  task automatic test_back_to_back();
    issue(4'd13, 1'b0, 8'h00, 8'd3, 8'd3,  4'b0000, 1'b1);
    issue(4'd0,  1'b1, 8'hFF, 8'd4, 8'd7,  4'b0000, 1'b1);
    issue(4'd9,  1'b1, 8'hFF, 8'd0, 8'd14, 4'b0000, 1'b1);
    idle();
    single(4'd0, 1'b1, 8'h00, 8'h00, 8'd14, 4'b0000);
  endtask

  task automatic test_reset_mul();
    issue(4'd11, 1'b0, 8'hFF, 8'hFF, 8'h00, 4'b0000, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (result !== '0 || flags !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_during_mul got res=%h flg=%b ov=%b busy=%b exp all 0",
               result, flags, out_valid, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_reset got rdy=%b busy=%b exp 1 0", in_ready, busy);
    end
    single(4'd0, 1'b1, 8'h00, 8'h00, 8'h00, 4'b1000);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_logic();
    test_compare();
    test_mul();
    test_back_to_back();
    test_reset_mul();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
